// File: rtl/seg_argmax.sv
// Per-pixel class argmax over four fixed-point scores, 2-stage compare tree,
// with a per-frame class histogram presented at each frame boundary.
module seg_argmax #(
    parameter int HEIGHT    = 480,
    parameter int WIDTH     = 640,
    parameter int W_HEIGHT  = 525,
    parameter int W_WIDTH   = 800,
    parameter int INT_BITW  = 5,
    parameter int FRAC_BITW = 8,
    parameter int CNT_BITW  = 20,
    localparam int V_BITW     = $clog2(W_HEIGHT),
    localparam int H_BITW     = $clog2(W_WIDTH),
    localparam int FIXED_BITW = INT_BITW + FRAC_BITW
) (
    input  logic                      clock,
    input  logic                      n_rst,
    input  logic [0:FIXED_BITW*4-1]   in_y,
    input  logic [V_BITW-1:0]         in_vcnt,
    input  logic [H_BITW-1:0]         in_hcnt,
    output logic [1:0]                out_label,
    output logic [FIXED_BITW-1:0]     out_score,
    output logic [V_BITW-1:0]         out_vcnt,
    output logic [H_BITW-1:0]         out_hcnt,
    output logic [0:CNT_BITW*4-1]     out_hist,
    output logic                      out_hist_valid
);

    localparam logic [CNT_BITW-1:0] CNT_MAX = '1;

    logic signed [FIXED_BITW-1:0] sc [4];

    logic [1:0]                   p01_idx;
    logic signed [FIXED_BITW-1:0] p01_sc;
    logic [1:0]                   p23_idx;
    logic signed [FIXED_BITW-1:0] p23_sc;

    logic [1:0]                   s1_idx01;
    logic signed [FIXED_BITW-1:0] s1_sc01;
    logic [1:0]                   s1_idx23;
    logic signed [FIXED_BITW-1:0] s1_sc23;
    logic [V_BITW-1:0]            s1_v;
    logic [H_BITW-1:0]            s1_h;
    logic                         s1_live;

    logic [1:0]                   nxt_label;
    logic [FIXED_BITW-1:0]        nxt_score;
    logic                         boundary;
    logic                         active;

    logic [CNT_BITW-1:0] acc    [4];
    logic [CNT_BITW-1:0] acc_n  [4];
    logic [CNT_BITW-1:0] hist_q [4];
    logic [CNT_BITW-1:0] hist_n [4];
    logic                seen;
    logic                seen_n;
    logic                hv_n;

    // Unpack the four class scores; class 0 occupies the leading bits.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sc[i] = in_y[i*FIXED_BITW +: FIXED_BITW];
        end
    end

    // First compare level: pairs (0,1) and (2,3), lower index wins ties.
    always_comb begin
        p01_idx = 2'd0;
        p01_sc  = sc[0];
        p23_idx = 2'd2;
        p23_sc  = sc[2];
        if (sc[1] > sc[0]) begin
            p01_idx = 2'd1;
            p01_sc  = sc[1];
        end
        if (sc[3] > sc[2]) begin
            p23_idx = 2'd3;
            p23_sc  = sc[3];
        end
    end

    // Stage-1 register; s1_live marks that it holds a real pixel, so the
    // reset-cleared (0,0) bubble is never mistaken for a frame boundary.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            s1_idx01 <= '0;
            s1_sc01  <= '0;
            s1_idx23 <= '0;
            s1_sc23  <= '0;
            s1_v     <= '0;
            s1_h     <= '0;
            s1_live  <= 1'b0;
        end else begin
            s1_idx01 <= p01_idx;
            s1_sc01  <= p01_sc;
            s1_idx23 <= p23_idx;
            s1_sc23  <= p23_sc;
            s1_v     <= in_vcnt;
            s1_h     <= in_hcnt;
            s1_live  <= 1'b1;
        end
    end

    // Second compare level plus pixel classification of the stage-2 result.
    always_comb begin
        nxt_label = s1_idx01;
        nxt_score = s1_sc01;
        if (s1_sc23 > s1_sc01) begin
            nxt_label = s1_idx23;
            nxt_score = s1_sc23;
        end
        boundary = (s1_v == '0) && (s1_h == '0);
        active   = (32'(s1_v) < HEIGHT) && (32'(s1_h) < WIDTH);
    end

    // Stage-2 output register.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            out_label <= '0;
            out_score <= '0;
            out_vcnt  <= '0;
            out_hcnt  <= '0;
        end else begin
            out_label <= nxt_label;
            out_score <= nxt_score;
            out_vcnt  <= s1_v;
            out_hcnt  <= s1_h;
        end
    end

    // Histogram next state: publish at boundary, else saturating count.
    always_comb begin
        acc_n  = acc;
        hist_n = hist_q;
        seen_n = seen;
        hv_n   = 1'b0;
        if (s1_live) begin
            if (boundary) begin
                if (seen) begin
                    hist_n = acc;
                    hv_n   = 1'b1;
                end
                for (int i = 0; i < 4; i++) begin
                    acc_n[i] = '0;
                end
                acc_n[nxt_label] = CNT_BITW'(1);
                seen_n = 1'b1;
            end else if (active && acc[nxt_label] != CNT_MAX) begin
                acc_n[nxt_label] = acc[nxt_label] + CNT_BITW'(1);
            end
        end
    end

    // Histogram state registers.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 4; i++) begin
                acc[i]    <= '0;
                hist_q[i] <= '0;
            end
            seen           <= 1'b0;
            out_hist_valid <= 1'b0;
        end else begin
            acc            <= acc_n;
            hist_q         <= hist_n;
            seen           <= seen_n;
            out_hist_valid <= hv_n;
        end
    end

    // Pack the published counts, class 0 first.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            out_hist[i*CNT_BITW +: CNT_BITW] = hist_q[i];
        end
    end

endmodule

// File: tb/tb_seg_argmax.sv
// Scoreboard bench for seg_argmax: two instances (wide and 3-bit counters)
// share random/directed stimulus and are checked against a reference model.
module tb_seg_argmax;

    localparam int FB  = 13;
    localparam int CA  = 20;
    localparam int CB  = 3;
    localparam int HT  = 4;
    localparam int WD  = 4;
    localparam int WHT = 6;
    localparam int WWD = 6;
    localparam int VB  = 3;
    localparam int HB  = 3;

    typedef struct packed {
        int                   issue;
        logic [1:0]           lab;
        logic [FB-1:0]        score;
        logic [VB-1:0]        v;
        logic [HB-1:0]        h;
        logic                 hv;
        logic [3:0][CA-1:0]   ha;
        logic [3:0][CB-1:0]   hb;
    } item_t;

    logic              clock = 1'b0;
    logic              n_rst = 1'b1;
    logic [0:4*FB-1]   in_y  = '0;
    logic [VB-1:0]     in_vcnt = '0;
    logic [HB-1:0]     in_hcnt = '0;

    logic [1:0]        lab_a, lab_b;
    logic [FB-1:0]     sc_a, sc_b;
    logic [VB-1:0]     v_a, v_b;
    logic [HB-1:0]     h_a, h_b;
    logic [0:4*CA-1]   hist_a;
    logic [0:4*CB-1]   hist_b;
    logic              hv_a, hv_b;

    seg_argmax #(.HEIGHT(HT), .WIDTH(WD), .W_HEIGHT(WHT), .W_WIDTH(WWD),
                 .INT_BITW(5), .FRAC_BITW(8), .CNT_BITW(CA)) dut_a (
        .clock(clock), .n_rst(n_rst), .in_y(in_y),
        .in_vcnt(in_vcnt), .in_hcnt(in_hcnt),
        .out_label(lab_a), .out_score(sc_a),
        .out_vcnt(v_a), .out_hcnt(h_a),
        .out_hist(hist_a), .out_hist_valid(hv_a));

    seg_argmax #(.HEIGHT(HT), .WIDTH(WD), .W_HEIGHT(WHT), .W_WIDTH(WWD),
                 .INT_BITW(5), .FRAC_BITW(8), .CNT_BITW(CB)) dut_b (
        .clock(clock), .n_rst(n_rst), .in_y(in_y),
        .in_vcnt(in_vcnt), .in_hcnt(in_hcnt),
        .out_label(lab_b), .out_score(sc_b),
        .out_vcnt(v_b), .out_hcnt(h_b),
        .out_hist(hist_b), .out_hist_valid(hv_b));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    int    checks = 0;
    int    errors = 0;
    item_t q[$];

    // reference model state
    int acc [2][4];
    int hist[2][4];
    bit seen;
    int cmax[2] = '{(1 << CA) - 1, (1 << CB) - 1};

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t",
                     n, a, e, $time);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                acc[d][c]  = 0;
                hist[d][c] = 0;
            end
        end
        seen = 0;
    endtask

    // Drive one pixel, predict its output, wait one cycle.
    task automatic px(input logic signed [FB-1:0] s0,
                      input logic signed [FB-1:0] s1,
                      input logic signed [FB-1:0] s2,
                      input logic signed [FB-1:0] s3,
                      input int v, input int h);
        logic signed [FB-1:0] s[4];
        int    best;
        item_t it;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int c = 0; c < 4; c++) in_y[c*FB +: FB] = s[c];
        in_vcnt = VB'(v);
        in_hcnt = HB'(h);
        best = 0;
        for (int c = 1; c < 4; c++) if (s[c] > s[best]) best = c;
        it.issue = cyc;
        it.lab   = 2'(best);
        it.score = s[best];
        it.v     = VB'(v);
        it.h     = HB'(h);
        it.hv    = 1'b0;
        if (v == 0 && h == 0) begin
            if (seen) begin
                it.hv = 1'b1;
                for (int d = 0; d < 2; d++)
                    for (int c = 0; c < 4; c++) hist[d][c] = acc[d][c];
            end
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 4; c++) acc[d][c] = 0;
                acc[d][best] = 1;
            end
            seen = 1;
        end else if (v < HT && h < WD) begin
            for (int d = 0; d < 2; d++)
                if (acc[d][best] < cmax[d]) acc[d][best]++;
        end
        for (int c = 0; c < 4; c++) begin
            it.ha[c] = CA'(hist[0][c]);
            it.hb[c] = CB'(hist[1][c]);
        end
        q.push_back(it);
        @(negedge clock);
    endtask

    function automatic logic signed [FB-1:0] rnd_lo();
        int r;
        r = int'($urandom_range(0, 8190)) - 4096;
        return FB'(r);
    endfunction

    // Pixel whose winner is class c (winner takes the max positive score).
    task automatic px_class(input int c, input int v, input int h);
        logic signed [FB-1:0] s[4];
        for (int i = 0; i < 4; i++) s[i] = rnd_lo();
        s[c] = 13'sh0FFF;
        px(s[0], s[1], s[2], s[3], v, h);
    endtask

    // Score from a small set so ties are frequent.
    function automatic logic signed [FB-1:0] rnd_tie();
        logic signed [FB-1:0] vals[7];
        vals = '{-13'sd4096, -13'sd256, -13'sd1, 13'sd0,
                 13'sd1, 13'sd256, 13'sd4095};
        return vals[$urandom_range(0, 6)];
    endfunction

    // mode 0: active class 3, blanking class 0; 1: 5/6/3/2 mix;
    // 2: active class 2; 3: fully random. stop >= 0 ends early.
    task automatic frame(input int mode, input int stop);
        int n, k;
        n = 0;
        k = 0;
        for (int v = 0; v < WHT; v++) begin
            for (int h = 0; h < WWD; h++) begin
                if (stop >= 0 && k == stop) return;
                k++;
                if (mode == 3) begin
                    px(rnd_tie(), rnd_tie(), rnd_tie(), rnd_tie(), v, h);
                end else if (v < HT && h < WD) begin
                    case (mode)
                        0: px_class(3, v, h);
                        1: px_class(n < 5 ? 0 : n < 11 ? 1 : n < 14 ? 2 : 3,
                                    v, h);
                        default: px_class(2, v, h);
                    endcase
                    n++;
                end else begin
                    px_class(mode == 0 ? 0 : int'($urandom_range(0, 3)), v, h);
                end
            end
        end
    endtask

    task automatic do_reset();
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_label_a", 32'(lab_a), 0);
        chk("rst_score_a", 32'(sc_a), 0);
        chk("rst_vcnt_a", 32'(v_a), 0);
        chk("rst_hcnt_a", 32'(h_a), 0);
        chk("rst_hist_a", 32'(|hist_a), 0);
        chk("rst_hv_a", 32'(hv_a), 0);
        chk("rst_label_b", 32'(lab_b), 0);
        chk("rst_hist_b", 32'(|hist_b), 0);
        chk("rst_hv_b", 32'(hv_b), 0);
        q.delete();
        model_clear();
        @(negedge clock);
        @(negedge clock);
        n_rst = 1'b1;
    endtask

    // Monitor: compare each output against the queued prediction.
    always @(negedge clock) begin
        item_t e;
        if (q.size() > 0 && q[0].issue + 2 == cyc) begin
            e = q.pop_front();
            chk("label_a", 32'(lab_a), 32'(e.lab));
            chk("score_a", 32'(sc_a), 32'(e.score));
            chk("vcnt_a", 32'(v_a), 32'(e.v));
            chk("hcnt_a", 32'(h_a), 32'(e.h));
            chk("hv_a", 32'(hv_a), 32'(e.hv));
            chk("label_b", 32'(lab_b), 32'(e.lab));
            chk("score_b", 32'(sc_b), 32'(e.score));
            chk("hv_b", 32'(hv_b), 32'(e.hv));
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("hist_a[%0d]", c),
                    32'(hist_a[c*CA +: CA]), 32'(e.ha[c]));
                chk($sformatf("hist_b[%0d]", c),
                    32'(hist_b[c*CB +: CB]), 32'(e.hb[c]));
            end
        end
    end

    initial begin
        model_clear();
        @(negedge clock);
        do_reset();
        // directed compare-tree vectors
        px(13'sh0100, 13'sh0280, 13'sh1F80, 13'sh0200, 3, 7);
        px(13'sh0080, 13'sh0080, 13'sh0080, 13'sh0080, 5, 5);
        px(-13'sd256, -13'sd256, -13'sd512, -13'sd256, 4, 6);
        px(-13'sd1024, -13'sd768, -13'sd768, -13'sd2048, 3, 6);
        // histogram frames
        frame(0, -1);
        frame(0, -1);
        frame(1, -1);
        frame(2, -1);
        frame(3, -1);
        frame(3, 20);
        do_reset();
        frame(3, -1);
        frame(1, -1);
        frame(3, -1);
        frame(0, 1);
        px_class(1, 5, 5);
        px_class(2, 5, 4);
        @(negedge clock);
        @(negedge clock);
        chk("drain", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_argmax.md
# seg_argmax

Per-pixel class decision stage directly downstream of the 1×1 convolution head of the segmentation CNN. Takes the four signed fixed-point class scores produced each cycle and outputs the winning class index and its score through a 2-stage pipelined comparator tree. Keeps per-frame class pixel counts and presents them once per frame. Coordinates travel with the data so the next stage (colour mapping / display) stays aligned.

## Interface
- HEIGHT, -1: active image height (rows).
- WIDTH, -1: active image width (columns).
- W_HEIGHT, -1: full frame height including blanking; V_BITW = ceil(log2(W_HEIGHT)).
- W_WIDTH, -1: full frame width including blanking; H_BITW = ceil(log2(W_WIDTH)).
- INT_BITW, 5: integer bits of each score (sign included).
- FRAC_BITW, 8: fractional bits of each score; FIXED_BITW = INT_BITW + FRAC_BITW.
- CNT_BITW, 20: width of each histogram counter.
- clock  in  1  single system clock; all logic on rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- in_y  in  [0:FIXED_BITW*4-1]  four two's-complement scores; class 0 in bits [0:FIXED_BITW-1], class 3 last.
- in_vcnt  in  V_BITW  row coordinate of in_y.
- in_hcnt  in  H_BITW  column coordinate of in_y.
- out_label  out  2  winning class index.
- out_score  out  FIXED_BITW  winning score, unchanged format.
- out_vcnt  out  V_BITW  in_vcnt delayed 2 cycles.
- out_hcnt  out  H_BITW  in_hcnt delayed 2 cycles.
- out_hist  out  [0:CNT_BITW*4-1]  pixel count per class for last complete frame; class 0 first.
- out_hist_valid  out  1  one-cycle pulse when out_hist updates.

## Operation
- Input accepted every cycle; no enable or back-pressure.
- Comparisons are signed on full FIXED_BITW.
- Stage 1: pair (0,1) and pair (2,3); winner = higher score; tie → lower index. Register winner index (2 bits) and score per pair, plus coordinates.
- Stage 2: compare pair winners, same tie rule (pair (0,1) wins ties). Register out_label, out_score, out_vcnt, out_hcnt.
- Active pixel: stage-2 coordinate with vcnt < HEIGHT and hcnt < WIDTH. Blanking positions still produce label/score but are not counted.
- Histogram, evaluated on stage-2 result (same cycle the result is registered):
  - Frame boundary = stage-2 coordinate (0,0).
  - At boundary with `seen`=1: out_hist ← accumulators; out_hist_valid ← 1; accumulators ← 0 except winning class ← 1.
  - At boundary with `seen`=0 (first frame after reset): no pulse; accumulators cleared then winning class ← 1; seen ← 1.
  - Otherwise: active pixel increments the winning class counter.
  - Counters saturate at 2^CNT_BITW−1; no wrap.
- `seen` is an internal flag, cleared only by reset.

## Timing
- Latency in_y → out_label/out_score: exactly 2 cycles; coordinates identical latency.
- out_hist/out_hist_valid change in the same cycle out_vcnt/out_hcnt = (0,0) is presented; out_hist holds until next boundary.
- out_hist_valid high for exactly 1 cycle per frame (from second frame after reset).
- Reset (async assert, any time): out_label, out_score, out_vcnt, out_hcnt, out_hist, out_hist_valid, all pipeline registers, accumulators, `seen` → 0. Partial frame in progress discarded; next (0,0) behaves as first frame.
- Out-of-order or repeated (0,0) coordinates: each (0,0) treated as a boundary; no other sanity checking.

## Test plan
- Scores (1.0, 2.5, −0.5, 2.0) = (0x100, 0x280, 0x1F80, 0x200) at coord (3,7) → 2 cycles later out_label=1, out_score=0x280, out_vcnt=3, out_hcnt=7.
- All four scores equal 0x080 → out_label=0; scores (−1,−1,−2,−1) → out_label=0; (−4,−3,−3,−8) → out_label=1 (tie rule, signed compare).
- HEIGHT=4, WIDTH=4, W_HEIGHT=6, W_WIDTH=6, two frames with class 3 winning all 16 active pixels and class 0 winning blanking → first (0,0) no pulse; second-frame boundary pulses out_hist=(0,0,0,16) for one cycle.
- Mixed frame: 5 pixels class 0, 6 class 1, 3 class 2, 2 class 3 → next boundary out_hist=(5,6,3,2); value held until following boundary.
- CNT_BITW=3, 16 active pixels all class 2 → out_hist class 2 = 7 (saturated), others 0.
- Assert n_rst mid-frame → all outputs 0 immediately; after release, first (0,0) gives no pulse, second gives counts of one full frame only.
